// File: rtl/sw_seq_feeder_pkg.sv
// Shared constants and state encodings for the SmithWaterman sequence feeder.
package sw_seq_feeder_pkg;

  localparam int unsigned SW_CHUNK   = 64;
  localparam int unsigned SW_VALID_W = 7;

  typedef enum logic [2:0] {
    M_IDLE,
    M_T_PULSE,
    M_T_WAIT,
    M_T_STREAM,
    M_C_PULSE,
    M_C_WAIT,
    M_C_RUN
  } main_state_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RD,
    S_OUT
  } s_state_e;

  // S chunks may only be served while the core is in a calculation pass.
  function automatic logic in_cal_phase(input main_state_e st);
    return (st == M_C_WAIT) || (st == M_C_RUN);
  endfunction

endpackage

// File: rtl/sw_seq_feeder_if.sv
// Memory-side and core-side bus of the sequence feeder; master = feeder, slave = memories/core.
interface sw_seq_feeder_if
  import sw_seq_feeder_pkg::*;
#(
  parameter int unsigned T_ADDR_W = 10,
  parameter int unsigned T_W      = 18,
  parameter int unsigned S_ADDR_W = 8,
  parameter int unsigned S_W      = 128,
  parameter int unsigned VALID_W  = SW_VALID_W
);

  logic [T_ADDR_W-1:0] o_t_addr;
  logic [T_W-1:0]      i_t_rdata;
  logic [S_ADDR_W-1:0] o_s_addr;
  logic                o_s_rd;
  logic [S_W-1:0]      i_s_rdata;
  logic                o_set_t;
  logic                o_start_cal;
  logic [15:0]         o_param;
  logic [T_W-1:0]      o_t;
  logic [S_W-1:0]      o_s;
  logic [VALID_W-1:0]  o_s_valid;
  logic                i_busy;
  logic                i_request_s;

  modport master (
    output o_t_addr, o_s_addr, o_s_rd, o_set_t, o_start_cal, o_param, o_t, o_s, o_s_valid,
    input  i_t_rdata, i_s_rdata, i_busy, i_request_s
  );

  modport slave (
    input  o_t_addr, o_s_addr, o_s_rd, o_set_t, o_start_cal, o_param, o_t, o_s, o_s_valid,
    output i_t_rdata, i_s_rdata, i_busy, i_request_s
  );

endinterface

// File: rtl/sw_s_chunker.sv
// S sub-FSM: fetches one S word per core request and presents it with its symbol count.
// Optional SW_FEEDER_STATS_EN adds delivered-word and request-stall counters.
module sw_s_chunker
  import sw_seq_feeder_pkg::*;
#(
  parameter int unsigned S_ADDR_W = 8,
  parameter int unsigned S_W      = 128,
  parameter int unsigned CHUNK    = SW_CHUNK,
  parameter int unsigned VALID_W  = SW_VALID_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                active,
  input  logic                request_s,
  input  logic [15:0]         s_total,
  input  logic [S_W-1:0]      s_rdata,
  output logic [S_ADDR_W-1:0] s_addr,
  output logic                s_rd,
  output logic [S_W-1:0]      s,
  output logic [VALID_W-1:0]  s_valid
`ifdef SW_FEEDER_STATS_EN
  ,
  input  logic                clear,
  output logic [15:0]         s_words,
  output logic [15:0]         req_stall
`endif
);

  localparam logic [15:0] CHUNK16 = 16'(CHUNK);

  s_state_e       st;
  s_state_e       st_nx;
  logic [15:0]    rem;
  logic [S_W-1:0] word;
  logic           last;

  assign last = (rem <= CHUNK16);

  always_comb begin
    st_nx = st;
    s_rd  = 1'b0;
    case (st)
      S_IDLE: begin
        if (request_s) begin
          s_rd  = 1'b1;
          st_nx = S_RD;
        end
      end
      S_RD:    st_nx = S_OUT;
      S_OUT:   st_nx = S_IDLE;
      default: st_nx = S_IDLE;
    endcase
    if (!active) begin
      st_nx = S_IDLE;
      s_rd  = 1'b0;
    end
  end

  // Leaving the active window (busy low or no pass running) rewinds S to its start.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st     <= S_IDLE;
      s_addr <= '0;
      rem    <= '0;
      word   <= '0;
    end else if (!active) begin
      st     <= S_IDLE;
      s_addr <= '0;
      rem    <= s_total;
    end else begin
      st <= st_nx;
      if (st == S_RD) begin
        word <= s_rdata;
      end
      if (st == S_OUT) begin
        if (last) begin
          s_addr <= '0;
          rem    <= s_total;
        end else begin
          s_addr <= s_addr + 1'b1;
          rem    <= rem - CHUNK16;
        end
      end
    end
  end

  always_comb begin
    s       = '0;
    s_valid = '0;
    if (active && (st == S_OUT)) begin
      s       = word;
      s_valid = last ? rem[VALID_W-1:0] : '1;
    end
  end

`ifdef SW_FEEDER_STATS_EN
  logic fetching;
  assign fetching = active && ((st != S_IDLE) || request_s);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_words   <= '0;
      req_stall <= '0;
    end else if (clear) begin
      s_words   <= '0;
      req_stall <= '0;
    end else begin
      if ((s_valid != '0) && (s_words != '1)) begin
        s_words <= s_words + 16'd1;
      end
      if (request_s && !fetching && (req_stall != '1)) begin
        req_stall <= req_stall + 16'd1;
      end
    end
  end
`endif

endmodule

// File: rtl/sw_seq_feeder.sv
// Sequence source for the SmithWaterman core: T load streaming, calculation start, S chunk service.
// Optional SW_FEEDER_STATS_EN exposes o_s_words / o_req_stall counters.
module sw_seq_feeder
  import sw_seq_feeder_pkg::*;
#(
  parameter int unsigned T_ADDR_W = 10,
  parameter int unsigned T_W      = 18,
  parameter int unsigned S_ADDR_W = 8,
  parameter int unsigned S_W      = 128,
  parameter int unsigned CHUNK    = SW_CHUNK,
  parameter int unsigned VALID_W  = SW_VALID_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load_t,
  input  logic             i_start,
  input  logic [15:0]      i_param,
  input  logic [15:0]      i_s_total,
  sw_seq_feeder_if.master  bus,
  output logic             o_cfg_err
`ifdef SW_FEEDER_STATS_EN
  ,
  output logic [15:0]      o_s_words,
  output logic [15:0]      o_req_stall
`endif
);

  main_state_e         state;
  main_state_e         state_nx;
  logic                start_accept;
  logic [T_ADDR_W-1:0] t_addr;
  logic [T_W-1:0]      t_word;
  logic [15:0]         param_q;
  logic [15:0]         s_total_q;
  logic                cfg_err;

  // i_load_t has priority; a start in the same cycle is dropped.
  assign start_accept = (state == M_IDLE) && i_start && !i_load_t;

  always_comb begin
    state_nx = state;
    case (state)
      M_IDLE: begin
        if (i_load_t) begin
          state_nx = M_T_PULSE;
        end else if (i_start && (i_s_total != '0)) begin
          state_nx = M_C_PULSE;
        end
      end
      M_T_PULSE:  state_nx = M_T_WAIT;
      M_T_WAIT:   state_nx = M_T_STREAM;
      M_T_STREAM: if (!bus.i_busy) state_nx = M_IDLE;
      M_C_PULSE:  state_nx = M_C_WAIT;
      M_C_WAIT:   if (bus.i_busy) state_nx = M_C_RUN;
      M_C_RUN:    if (!bus.i_busy) state_nx = M_IDLE;
      default:    state_nx = M_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= M_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Address runs one ahead of the streamed word to cover the 1-cycle read latency.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      t_addr    <= '0;
      param_q   <= '0;
      s_total_q <= '0;
      cfg_err   <= 1'b0;
    end else begin
      t_addr <= (state_nx == M_T_STREAM) ? t_addr + 1'b1 : '0;
      if (start_accept) begin
        param_q   <= i_param;
        s_total_q <= i_s_total;
        if (i_s_total == '0) begin
          cfg_err <= 1'b1;
        end
      end
    end
  end

  // The exit cycle (busy already low) is not a stream cycle, so o_t is held at zero there.
  assign t_word = ((state == M_T_STREAM) && bus.i_busy) ? bus.i_t_rdata : '0;

  assign bus.o_t_addr    = t_addr;
  assign bus.o_t         = t_word;
  assign bus.o_set_t     = (state == M_T_PULSE);
  assign bus.o_start_cal = (state == M_C_PULSE);
  assign bus.o_param     = param_q;
  assign o_cfg_err       = cfg_err;

  sw_s_chunker #(
    .S_ADDR_W (S_ADDR_W),
    .S_W      (S_W),
    .CHUNK    (CHUNK),
    .VALID_W  (VALID_W)
  ) u_chunker (
    .clk       (clk),
    .rst       (rst),
    .active    (in_cal_phase(state) && bus.i_busy),
    .request_s (bus.i_request_s),
    .s_total   (s_total_q),
    .s_rdata   (bus.i_s_rdata),
    .s_addr    (bus.o_s_addr),
    .s_rd      (bus.o_s_rd),
    .s         (bus.o_s),
    .s_valid   (bus.o_s_valid)
`ifdef SW_FEEDER_STATS_EN
    ,
    .clear     (start_accept),
    .s_words   (o_s_words),
    .req_stall (o_req_stall)
`endif
  );

endmodule

// File: tb/tb_sw_seq_feeder.sv
// Scoreboard bench for sw_seq_feeder: stimulus pushes expectations, a negedge monitor pops them.
module tb_sw_seq_feeder;
  import sw_seq_feeder_pkg::*;

  localparam int unsigned T_ADDR_W = 10;
  localparam int unsigned T_W      = 18;
  localparam int unsigned S_ADDR_W = 8;
  localparam int unsigned S_W      = 128;
  localparam int unsigned VALID_W  = 7;
  localparam int unsigned T_DEPTH  = 1 << T_ADDR_W;
  localparam int unsigned S_DEPTH  = 1 << S_ADDR_W;

  logic        clk = 1'b0;
  logic        rst;
  logic        load_t;
  logic        start;
  logic [15:0] param;
  logic [15:0] s_total;
  logic        cfg_err;
`ifdef SW_FEEDER_STATS_EN
  logic [15:0] s_words;
  logic [15:0] req_stall;
`endif

  sw_seq_feeder_if #(
    .T_ADDR_W (T_ADDR_W), .T_W (T_W), .S_ADDR_W (S_ADDR_W), .S_W (S_W), .VALID_W (VALID_W)
  ) bus ();

  sw_seq_feeder #(
    .T_ADDR_W (T_ADDR_W), .T_W (T_W), .S_ADDR_W (S_ADDR_W), .S_W (S_W),
    .CHUNK (64), .VALID_W (VALID_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .i_load_t  (load_t),
    .i_start   (start),
    .i_param   (param),
    .i_s_total (s_total),
    .bus       (bus),
    .o_cfg_err (cfg_err)
`ifdef SW_FEEDER_STATS_EN
    ,
    .o_s_words   (s_words),
    .o_req_stall (req_stall)
`endif
  );

  always #5 clk = ~clk;

  // Sequence memories with 1-cycle read latency
  logic [T_W-1:0] tmem [T_DEPTH];
  logic [S_W-1:0] smem [S_DEPTH];

  always @(posedge clk) bus.i_t_rdata <= tmem[bus.o_t_addr];
  always @(posedge clk) if (bus.o_s_rd) bus.i_s_rdata <= smem[bus.o_s_addr];

  typedef struct packed {
    logic [VALID_W-1:0] valid;
    logic [S_W-1:0]     data;
  } s_exp_t;

  typedef struct packed {
    logic        is_cal;
    logic [15:0] param;
  } p_exp_t;

  s_exp_t         sq[$];
  p_exp_t         pq[$];
  logic [T_W-1:0] tq[$];

  int unsigned checks = 0;
  int unsigned errors = 0;
  int unsigned s_seen = 0;

  // Reference: S is cut into ceil(total/64) chunks; all but the last are full words.
  function automatic s_exp_t s_model(input int unsigned total, input int unsigned idx);
    int unsigned n;
    int unsigned p;
    s_exp_t      e;
    n       = (total + 63) / 64;
    p       = idx % n;
    e.data  = smem[p];
    e.valid = (p == n - 1) ? VALID_W'(total - 64 * (n - 1)) : '1;
    return e;
  endfunction

  p_exp_t         mp;
  s_exp_t         ms;
  logic [T_W-1:0] mt;
  logic           prev_valid = 1'b0;

  always @(negedge clk) begin
    if (rst) begin
      prev_valid = 1'b0;
    end else begin
      if (bus.o_set_t || bus.o_start_cal) begin
        checks++;
        if (pq.size() == 0) begin
          errors++;
          $display("FAIL pulse: got set_t=%0b start_cal=%0b, required no pulse",
                   bus.o_set_t, bus.o_start_cal);
        end else begin
          mp = pq.pop_front();
          if ((bus.o_set_t == mp.is_cal) || (bus.o_start_cal != mp.is_cal) ||
              (mp.is_cal && (bus.o_param != mp.param))) begin
            errors++;
            $display("FAIL pulse: got set_t=%0b start_cal=%0b param=%h, required start_cal=%0b param=%h",
                     bus.o_set_t, bus.o_start_cal, bus.o_param, mp.is_cal, mp.param);
          end
        end
      end
      if (bus.o_t != '0) begin
        checks++;
        if (tq.size() == 0) begin
          errors++;
          $display("FAIL t_stream: got %h, required no word", bus.o_t);
        end else begin
          mt = tq.pop_front();
          if (bus.o_t != mt) begin
            errors++;
            $display("FAIL t_stream: got %h required %h", bus.o_t, mt);
          end
        end
      end
      checks++;
      if (bus.o_s_valid != '0) begin
        s_seen++;
        if (prev_valid) begin
          errors++;
          $display("FAIL s_spacing: got valid on consecutive cycles, required gap");
        end
        if (sq.size() == 0) begin
          errors++;
          $display("FAIL s_chunk: got valid=%0d, required no chunk", bus.o_s_valid);
        end else begin
          ms = sq.pop_front();
          if ((bus.o_s_valid != ms.valid) || (bus.o_s != ms.data)) begin
            errors++;
            $display("FAIL s_chunk: got valid=%0d s=%h required valid=%0d s=%h",
                     bus.o_s_valid, bus.o_s, ms.valid, ms.data);
          end
        end
      end else if (bus.o_s != '0) begin
        errors++;
        $display("FAIL s_zero: got %h required 0", bus.o_s);
      end
      prev_valid = (bus.o_s_valid != '0);
    end
  end

  task automatic cyc(input int unsigned n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [S_W-1:0] got, input logic [S_W-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", name, got, exp);
    end
  endtask

  task automatic drained(input string name);
    check({name, " pulses_left"}, S_W'(pq.size()), '0);
    check({name, " t_left"}, S_W'(tq.size()), '0);
    check({name, " s_left"}, S_W'(sq.size()), '0);
  endtask

  task automatic check_quiet(input string name);
    check({name, " t_addr"}, S_W'(bus.o_t_addr), '0);
    check({name, " s_addr"}, S_W'(bus.o_s_addr), '0);
    check({name, " s_rd"}, S_W'(bus.o_s_rd), '0);
    check({name, " set_t"}, S_W'(bus.o_set_t), '0);
    check({name, " start_cal"}, S_W'(bus.o_start_cal), '0);
    check({name, " param"}, S_W'(bus.o_param), '0);
    check({name, " t"}, S_W'(bus.o_t), '0);
    check({name, " s"}, bus.o_s, '0);
    check({name, " s_valid"}, S_W'(bus.o_s_valid), '0);
    check({name, " cfg_err"}, S_W'(cfg_err), '0);
`ifdef SW_FEEDER_STATS_EN
    check({name, " s_words"}, S_W'(s_words), '0);
    check({name, " req_stall"}, S_W'(req_stall), '0);
`endif
  endtask

  task automatic run_t(input int unsigned nwords);
    pq.push_back('{is_cal: 1'b0, param: 16'h0});
    for (int unsigned i = 0; i < nwords; i++) tq.push_back(tmem[i % T_DEPTH]);
    load_t = 1'b1;
    cyc(1);
    load_t = 1'b0;
    cyc(1);
    bus.i_busy = 1'b1;
    cyc(nwords + 1);
    bus.i_busy = 1'b0;
    cyc(3);
    check("t_after", S_W'(bus.o_t), '0);
    drained("run_t");
  endtask

  task automatic run_s(input int unsigned total, input int unsigned nchunks, input bit abort);
    logic [15:0] prm;
    int unsigned base;
    int unsigned n;
    prm  = 16'($urandom);
    base = s_seen;
    for (int unsigned i = 0; i < nchunks; i++) sq.push_back(s_model(total, i));
    pq.push_back('{is_cal: 1'b1, param: prm});
    start   = 1'b1;
    param   = prm;
    s_total = 16'(total);
    cyc(1);
    start          = 1'b0;
    bus.i_busy      = 1'b1;
    bus.i_request_s = 1'b1;
    if (abort) begin
      cyc(2);
    end else begin
      n = 0;
      while ((s_seen - base < nchunks) && (n < 300)) begin
        cyc(1);
        n++;
      end
      if (n >= 300) begin
        checks++;
        errors++;
        $display("FAIL s_timeout: got %0d chunks required %0d", s_seen - base, nchunks);
      end
    end
    bus.i_request_s = 1'b0;
    bus.i_busy      = 1'b0;
    cyc(3);
    check("param_hold", S_W'(bus.o_param), S_W'(prm));
`ifdef SW_FEEDER_STATS_EN
    if (!abort) check("s_words", S_W'(s_words), S_W'(nchunks));
`endif
    drained("run_s");
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish, required finish");
    $fatal(1);
  end

  initial begin
    for (int unsigned i = 0; i < T_DEPTH; i++) tmem[i] = T_W'($urandom) | T_W'(1);
    for (int unsigned i = 0; i < S_DEPTH; i++)
      smem[i] = {$urandom, $urandom, $urandom, $urandom};
    rst = 1'b1; load_t = 1'b0; start = 1'b0; param = '0; s_total = '0;
    bus.i_busy = 1'b0; bus.i_request_s = 1'b0;
    cyc(2);
    check_quiet("reset");
    rst = 1'b0;
    cyc(1);

    run_t(4);
    run_s(200, 6, 1'b0);
    run_s(64, 2, 1'b0);
    run_s(1, 1, 1'b0);
    run_s(128, 3, 1'b0);
    run_s(200, 0, 1'b1);
    run_s(200, 1, 1'b0);

    check("cfg_err_before", S_W'(cfg_err), '0);
    start = 1'b1; s_total = '0;
    cyc(1);
    start = 1'b0;
    cyc(2);
    check("cfg_err_set", S_W'(cfg_err), S_W'(1));
    drained("cfg");
    cyc(5);
    check("cfg_err_sticky", S_W'(cfg_err), S_W'(1));

    pq.push_back('{is_cal: 1'b0, param: 16'h0});
    load_t = 1'b1; start = 1'b1; s_total = 16'd50;
    cyc(1);
    load_t = 1'b0; start = 1'b0;
    cyc(5);
    drained("load_and_start");

    for (int unsigned k = 0; k < 6; k++) begin
      run_s($urandom_range(400, 1), $urandom_range(8, 1), 1'b0);
      run_t($urandom_range(8, 1));
    end
    run_t(T_DEPTH + 6);

    pq.push_back('{is_cal: 1'b0, param: 16'h0});
    tq.push_back(tmem[0]);
    tq.push_back(tmem[1]);
    load_t = 1'b1;
    cyc(1);
    load_t = 1'b0;
    cyc(1);
    bus.i_busy = 1'b1;
    cyc(3);
    rst = 1'b1;
    #1;
    check_quiet("rst_t_stream");
    bus.i_busy = 1'b0;
    cyc(1);
    rst = 1'b0;
    cyc(1);
    drained("rst_t_stream");

    param = 16'hBEEF;
    pq.push_back('{is_cal: 1'b1, param: 16'hBEEF});
    sq.push_back(s_model(200, 0));
    start = 1'b1; s_total = 16'd200;
    cyc(1);
    start = 1'b0; bus.i_busy = 1'b1; bus.i_request_s = 1'b1;
    cyc(5);
    rst = 1'b1;
    #1;
    check_quiet("rst_c_run");
    bus.i_busy = 1'b0; bus.i_request_s = 1'b0;
    cyc(1);
    rst = 1'b0;
    cyc(2);
    drained("rst_c_run");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
